// File: rtl/mem_rmw_arbiter.sv
// Two-requester arbiter in front of a small register-file memory.
// Each grant runs an atomic read-modify-write and returns the pre-op word.
module mem_rmw_arbiter #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              io_req0_valid,
    output logic              io_req0_ready,
    input  logic [ADDR_W-1:0] io_req0_addr,
    input  logic [1:0]        io_req0_op,
    input  logic [WIDTH-1:0]  io_req0_data,
    input  logic              io_req1_valid,
    output logic              io_req1_ready,
    input  logic [ADDR_W-1:0] io_req1_addr,
    input  logic [1:0]        io_req1_op,
    input  logic [WIDTH-1:0]  io_req1_data,
    output logic              io_resp_valid,
    output logic              io_resp_id,
    output logic [WIDTH-1:0]  io_resp_data,
    output logic              io_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_XOR   = 2'b11;

    state_t             state_reg;
    state_t             state_next;
    logic               prio_reg;       // requester favoured on the next tie
    logic               grant0;
    logic               grant1;
    logic [ADDR_W-1:0]  addr_reg;
    logic [1:0]         op_reg;
    logic [WIDTH-1:0]   data_reg;
    logic               id_reg;
    logic [WIDTH-1:0]   old_reg;
    logic [WIDTH-1:0]   new_value;
    logic [WIDTH-1:0]   mem_reg [DEPTH];
    logic               resp_valid_reg;
    logic               resp_id_reg;
    logic [WIDTH-1:0]   resp_data_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant0     = 1'b0;
        grant1     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (io_req0_valid && io_req1_valid) begin
                    grant0 = ~prio_reg;
                    grant1 = prio_reg;
                end else begin
                    grant0 = io_req0_valid;
                    grant1 = io_req1_valid;
                end
                if (grant0 || grant1) begin
                    state_next = ST_READ;
                end
            end
            ST_READ:  state_next = ST_WRITE;
            ST_WRITE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Readies are combinational from valid but forced low while reset is held.
    assign io_req0_ready = reset_n && grant0;
    assign io_req1_ready = reset_n && grant1;
    assign io_busy       = (state_reg != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_reg <= 1'b0;
            addr_reg <= '0;
            op_reg   <= OP_READ;
            data_reg <= '0;
            id_reg   <= 1'b0;
        end else if (grant0 || grant1) begin
            prio_reg <= grant0;
            addr_reg <= grant1 ? io_req1_addr : io_req0_addr;
            op_reg   <= grant1 ? io_req1_op   : io_req0_op;
            data_reg <= grant1 ? io_req1_data : io_req0_data;
            id_reg   <= grant1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            old_reg <= '0;
        end else if (state_reg == ST_READ) begin
            old_reg <= mem_reg[addr_reg];
        end
    end

    always_comb begin
        new_value = old_reg;
        case (op_reg)
            OP_READ:  new_value = old_reg;
            OP_WRITE: new_value = data_reg;
            OP_ADD:   new_value = old_reg + data_reg;
            OP_XOR:   new_value = old_reg ^ data_reg;
            default:  new_value = old_reg;
        endcase
    end

    // One write path; every word is cleared on reset so it lives in flops.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    mem_reg[gi] <= '0;
                end else if (state_reg == ST_WRITE && op_reg != OP_READ
                             && addr_reg == ADDR_W'(gi)) begin
                    mem_reg[gi] <= new_value;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid_reg <= 1'b0;
            resp_id_reg    <= 1'b0;
            resp_data_reg  <= '0;
        end else begin
            resp_valid_reg <= (state_reg == ST_WRITE);
            if (state_reg == ST_WRITE) begin
                resp_id_reg   <= id_reg;
                resp_data_reg <= old_reg;
            end
        end
    end

    assign io_resp_valid = resp_valid_reg;
    assign io_resp_id    = resp_id_reg;
    assign io_resp_data  = resp_data_reg;

endmodule

// File: tb/tb_mem_rmw_arbiter.sv
// Bench for mem_rmw_arbiter: directed vector table, reset-mid-op sequence,
// and randomized traffic checked against a word-array reference model.
module tb_mem_rmw_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_addr = '0, req1_addr = '0;
    logic [1:0]  req0_op = '0, req1_op = '0;
    logic [31:0] req0_data = '0, req1_data = '0;
    logic        resp_valid, resp_id, busy;
    logic [31:0] resp_data;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] last_resp = '0;

    logic [31:0] mmem [8];
    logic        m_last = 1'b1;

    always #5 clk = ~clk;

    mem_rmw_arbiter #(.WIDTH(32), .DEPTH(8), .ADDR_W(3)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .io_req0_valid (req0_valid),
        .io_req0_ready (req0_ready),
        .io_req0_addr  (req0_addr),
        .io_req0_op    (req0_op),
        .io_req0_data  (req0_data),
        .io_req1_valid (req1_valid),
        .io_req1_ready (req1_ready),
        .io_req1_addr  (req1_addr),
        .io_req1_op    (req1_op),
        .io_req1_data  (req1_data),
        .io_resp_valid (resp_valid),
        .io_resp_id    (resp_id),
        .io_resp_data  (resp_data),
        .io_busy       (busy)
    );

    typedef struct {
        logic        rst;
        logic        v0, v1;
        logic [1:0]  op0, op1;
        logic [2:0]  a0, a1;
        logic [31:0] d0, d1;
        logic        exp_id;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: whole-transaction semantics on a plain word array.
    task automatic model_step(input logic v0, input logic v1,
                              input logic [1:0] op0, input logic [2:0] a0, input logic [31:0] d0,
                              input logic [1:0] op1, input logic [2:0] a1, input logic [31:0] d1,
                              output logic id, output logic [31:0] old);
        logic [1:0]  op;
        logic [2:0]  a;
        logic [31:0] d;
        id  = (v0 && v1) ? ~m_last : v1;
        op  = id ? op1 : op0;
        a   = id ? a1 : a0;
        d   = id ? d1 : d0;
        old = mmem[a];
        case (op)
            2'b01:   mmem[a] = d;
            2'b10:   mmem[a] = old + d;
            2'b11:   mmem[a] = old ^ d;
            default: ;
        endcase
        m_last = id;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mmem[i] = '0;
        m_last    = 1'b1;
        last_resp = '0;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_id", {31'd0, resp_id}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n    = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    // Starts at a negedge in IDLE, returns at the negedge of the response cycle.
    task automatic issue(input logic v0, input logic [1:0] op0, input logic [2:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [1:0] op1, input logic [2:0] a1, input logic [31:0] d1,
                         input logic exp_id, input logic [31:0] exp_data, input string tag);
        req0_valid = v0; req0_op = op0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_op = op1; req1_addr = a1; req1_data = d1;
        #1;
        chk({tag, "_ready0"}, {31'd0, req0_ready}, {31'd0, ~exp_id});
        chk({tag, "_ready1"}, {31'd0, req1_ready}, {31'd0, exp_id});
        @(negedge clk);
        chk({tag, "_busy_rd"}, {31'd0, busy}, 32'd1);
        chk({tag, "_hold"}, resp_data, last_resp);
        chk({tag, "_rv_rd"}, {31'd0, resp_valid}, 32'd0);
        // Late/unaccepted traffic during the op must be ignored.
        req0_valid = 1'($urandom_range(0, 1)); req0_op = 2'($urandom); req0_addr = a0; req0_data = $urandom;
        req1_valid = 1'($urandom_range(0, 1)); req1_op = 2'($urandom); req1_addr = a1; req1_data = $urandom;
        #1;
        chk({tag, "_noready_rd"}, {30'd0, req1_ready, req0_ready}, 32'd0);
        @(negedge clk);
        chk({tag, "_busy_wr"}, {31'd0, busy}, 32'd1);
        chk({tag, "_rv_wr"}, {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, "_rv"}, {31'd0, resp_valid}, 32'd1);
        chk({tag, "_id"}, {31'd0, resp_id}, {31'd0, exp_id});
        chk({tag, "_data"}, resp_data, exp_data);
        chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
        last_resp = exp_data;
        $display("txn %s: v=%0d%0d id=%0d data=0x%08h", tag, v0, v1, resp_id, resp_data);
    endtask

    task automatic set_vec(input int i, input logic rst, input logic v0, input logic [1:0] op0,
                           input logic [2:0] a0, input logic [31:0] d0, input logic v1,
                           input logic [1:0] op1, input logic [2:0] a1, input logic [31:0] d1,
                           input logic exp_id, input logic [31:0] exp_data);
        tbl[i].rst = rst; tbl[i].v0 = v0; tbl[i].op0 = op0; tbl[i].a0 = a0; tbl[i].d0 = d0;
        tbl[i].v1 = v1; tbl[i].op1 = op1; tbl[i].a1 = a1; tbl[i].d1 = d1;
        tbl[i].exp_id = exp_id; tbl[i].exp_data = exp_data;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        id;
        logic [31:0] old;
        int          nvec;

        set_vec(0,  1, 1, 2'b00, 3'd5, 32'h0,        0, 2'b00, 3'd0, 32'h0, 0, 32'h0);
        set_vec(1,  0, 1, 2'b01, 3'd2, 32'hDEADBEEF, 0, 2'b00, 3'd0, 32'h0, 0, 32'h0);
        set_vec(2,  0, 0, 2'b00, 3'd0, 32'h0,        1, 2'b00, 3'd2, 32'h0, 1, 32'hDEADBEEF);
        set_vec(3,  0, 1, 2'b01, 3'd7, 32'hFFFFFFFF, 0, 2'b00, 3'd0, 32'h0, 0, 32'h0);
        set_vec(4,  0, 1, 2'b10, 3'd7, 32'h2,        0, 2'b00, 3'd0, 32'h0, 0, 32'hFFFFFFFF);
        set_vec(5,  0, 1, 2'b00, 3'd7, 32'h0,        0, 2'b00, 3'd0, 32'h0, 0, 32'h1);
        set_vec(6,  0, 1, 2'b11, 3'd3, 32'hA5A5A5A5, 0, 2'b00, 3'd0, 32'h0, 0, 32'h0);
        set_vec(7,  0, 0, 2'b00, 3'd0, 32'h0,        1, 2'b11, 3'd3, 32'hA5A5A5A5, 1, 32'hA5A5A5A5);
        set_vec(8,  0, 1, 2'b00, 3'd3, 32'h0,        0, 2'b00, 3'd0, 32'h0, 0, 32'h0);
        for (int k = 0; k < 6; k++)
            set_vec(9 + k, (k == 0), 1, 2'b10, 3'd0, 32'h1, 1, 2'b10, 3'd0, 32'h1,
                    1'(k % 2), 32'(k));
        set_vec(15, 0, 1, 2'b00, 3'd0, 32'h0, 0, 2'b00, 3'd0, 32'h0, 0, 32'd6);
        nvec = 16;

        @(negedge clk);
        for (int i = 0; i < nvec; i++) begin
            if (tbl[i].rst) do_reset();
            model_step(tbl[i].v0, tbl[i].v1, tbl[i].op0, tbl[i].a0, tbl[i].d0,
                       tbl[i].op1, tbl[i].a1, tbl[i].d1, id, old);
            issue(tbl[i].v0, tbl[i].op0, tbl[i].a0, tbl[i].d0,
                  tbl[i].v1, tbl[i].op1, tbl[i].a1, tbl[i].d1,
                  tbl[i].exp_id, tbl[i].exp_data, $sformatf("vec%0d", i));
        end

        // Idle with no requests: nothing happens, no back-to-back response pulse.
        @(negedge clk);
        chk("idle_rv", {31'd0, resp_valid}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Reset during the WRITE cycle discards the operation.
        req0_valid = 1'b1; req0_op = 2'b01; req0_addr = 3'd4; req0_data = 32'h1234;
        #1;
        chk("rstmid_ready0", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_busy_wr", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            chk("rstmid_norsp", {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        $display("txn rstmid: write to addr 4 discarded by reset");
        model_step(1, 1, 2'b00, 3'd4, 32'h0, 2'b00, 3'd1, 32'h0, id, old);
        issue(1, 2'b00, 3'd4, 32'h0, 1, 2'b00, 3'd1, 32'h0, 1'b0, 32'h0, "rstmid_read4");

        // Randomized traffic against the reference model.
        for (int t = 0; t < 200; t++) begin
            logic [1:0]  pick, op0, op1;
            logic [2:0]  a0, a1;
            logic [31:0] d0, d1;
            pick = 2'($urandom_range(1, 3));
            op0 = 2'($urandom); op1 = 2'($urandom);
            a0 = 3'($urandom); a1 = 3'($urandom);
            d0 = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            d1 = $urandom;
            model_step(pick[0], pick[1], op0, a0, d0, op1, a1, d1, id, old);
            issue(pick[0], op0, a0, d0, pick[1], op1, a1, d1, id, old, $sformatf("rnd%0d", t));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("rnd_gap_rv", {31'd0, resp_valid}, 32'd0);
                chk("rnd_gap_busy", {31'd0, busy}, 32'd0);
            end
        end

        // Final sweep: every word must match the model.
        for (int a = 0; a < 8; a++) begin
            model_step(1, 0, 2'b00, 3'(a), 32'h0, 2'b00, 3'd0, 32'h0, id, old);
            issue(1, 2'b00, 3'(a), 32'h0, 0, 2'b00, 3'd0, 32'h0, id, old, $sformatf("sweep%0d", a));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
